// File: rtl/gnt_slot_bank.sv
// Requester-side slot bank for a one-hot tree priority selector: holds tagged
// pending entries, drives req/sel_en, and registers each granted tag onto a valid/ready port.
module gnt_slot_bank #(
  parameter int N     = 16,
  parameter int TAG_W = 6,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             alloc_valid_i,
  input  logic [TAG_W-1:0] alloc_tag_i,
  output logic             alloc_ready_o,
  output logic [N-1:0]     req_o,
  output logic             sel_en_o,
  input  logic [N-1:0]     gnt_i,
  output logic             out_valid_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic [IDX_W-1:0] out_idx_o,
  input  logic             out_ready_i,
  output logic [IDX_W:0]   free_cnt_o,
  output logic             gnt_err_o
);

  logic [N-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [N];
  logic             out_valid_q, out_valid_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             gnt_err_q, gnt_err_d;

  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W:0]   used_cnt;
  logic [IDX_W-1:0] gnt_idx;
  logic [TAG_W-1:0] gnt_tag;
  logic             gnt_multi, gnt_hit_empty, gnt_bad;
  logic             accept, alloc_fire;

  assign req_o         = valid_q;
  assign alloc_ready_o = ~&valid_q;
  assign sel_en_o      = ~out_valid_q | out_ready_i;
  assign out_valid_o   = out_valid_q;
  assign out_tag_o     = out_tag_q;
  assign out_idx_o     = out_idx_q;
  assign gnt_err_o     = gnt_err_q;
  assign free_cnt_o    = (IDX_W+1)'(N) - used_cnt;

  // Lowest free slot, occupancy count, and one-hot grant decode (valid only when gnt is one-hot).
  always_comb begin
    alloc_idx = '0;
    used_cnt  = '0;
    gnt_idx   = '0;
    gnt_tag   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end
    for (int i = 0; i < N; i++) begin
      used_cnt = used_cnt + (IDX_W+1)'(valid_q[i]);
      if (gnt_i[i]) begin
        gnt_idx = gnt_idx | IDX_W'(i);
        gnt_tag = gnt_tag | tag_q[i];
      end
    end
  end

  assign gnt_multi     = |(gnt_i & (gnt_i - N'(1)));
  assign gnt_hit_empty = |(gnt_i & ~valid_q);
  assign gnt_bad       = (|gnt_i) & (gnt_multi | gnt_hit_empty | ~sel_en_o);
  assign accept        = (|gnt_i) & ~gnt_bad;
  assign alloc_fire    = alloc_valid_i & alloc_ready_o;

  // The allocated slot is free pre-edge and the granted slot is valid, so they never collide.
  always_comb begin
    valid_d     = valid_q;
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_idx_d   = out_idx_q;
    gnt_err_d   = gnt_err_q | gnt_bad;
    if (alloc_fire) valid_d[alloc_idx] = 1'b1;
    if (accept) begin
      valid_d     = valid_d & ~gnt_i;
      out_valid_d = 1'b1;
      out_tag_d   = gnt_tag;
      out_idx_d   = gnt_idx;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q     <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_idx_q   <= '0;
      gnt_err_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_idx_q   <= out_idx_d;
      gnt_err_q   <= gnt_err_d;
    end
  end

  // Slot tags are only meaningful under their valid bit, so they carry no reset.
  always_ff @(posedge clock_i) begin
    if (alloc_fire) tag_q[alloc_idx] <= alloc_tag_i;
  end

endmodule
